// File: rtl/hazard_ctrl_unit_if.sv
// Hazard control bundle between the pipeline datapath and the hazard unit.
// master = pipeline side, slave = hazard unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_branch;
  logic              redirect;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_alusrc;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  logic              dmem_req;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              imem_ready;
  logic              dmem_ready;
  logic              cnt_clr;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_bubble;
  logic              exmem_en;
  logic              memwb_en;
  logic              memwb_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        fwd_id_a;
  logic [1:0]        fwd_id_b;
  logic              dmem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [1:0]        state;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_branch, redirect,
    output ex_rd, ex_rs1, ex_rs2,
    output ex_regwrite, ex_memread, ex_alusrc,
    output mem_rd, mem_regwrite, mem_memread, dmem_req,
    output wb_rd, wb_regwrite,
    output imem_ready, dmem_ready, cnt_clr,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_bubble,
    input  exmem_en, memwb_en, memwb_bubble,
    input  fwd_a, fwd_b, fwd_id_a, fwd_id_b,
    input  dmem_err, stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_branch, redirect,
    input  ex_rd, ex_rs1, ex_rs2,
    input  ex_regwrite, ex_memread, ex_alusrc,
    input  mem_rd, mem_regwrite, mem_memread, dmem_req,
    input  wb_rd, wb_regwrite,
    input  imem_ready, dmem_ready, cnt_clr,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_bubble,
    output exmem_en, memwb_en, memwb_bubble,
    output fwd_a, fwd_b, fwd_id_a, fwd_id_b,
    output dmem_err, stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: stalls, flushes, forwarding selects,
// data-memory wait/abort FSM and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16,
  parameter int DMEM_TMO = 15
) (
  input logic              clk,
  input logic              reset,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    ABORT = 2'b10
  } state_t;

  localparam int WW = (DMEM_TMO < 1) ? 1 : $clog2(DMEM_TMO + 1);
  localparam logic [WW-1:0] TMO = WW'(DMEM_TMO);
  localparam logic [CNT_W-1:0] CMAX = '1;

  function automatic logic src_hit(
    input logic              v,
    input logic [REG_AW-1:0] rd,
    input logic              u1,
    input logic [REG_AW-1:0] r1,
    input logic              u2,
    input logic [REG_AW-1:0] r2
  );
    return v && (rd != '0) &&
      ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic              mv,
    input logic [REG_AW-1:0] mrd,
    input logic              wv,
    input logic [REG_AW-1:0] wrd,
    input logic [REG_AW-1:0] rs
  );
    if (mv && (mrd != '0) && (mrd == rs))
      return 2'b10;
    if (wv && (wrd != '0) && (wrd == rs))
      return 2'b01;
    return 2'b00;
  endfunction

  state_t            st_q;
  state_t            st_d;
  logic [WW-1:0]     wcnt_q;
  logic [WW-1:0]     wcnt_d;
  logic              err_q;
  logic              err_d;
  logic [CNT_W-1:0]  scnt_q;
  logic [CNT_W-1:0]  fcnt_q;
  logic              freeze;
  logic              abort_c;
  logic              ex_ld;
  logic              ex_wr;
  logic              mem_ld;
  logic              mem_wr;
  logic              wb_wr;
  logic              stall_raw;
  logic              stall_e;
  logic              redir_e;
  logic              iwait_e;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_bubble;
  logic              exmem_en;
  logic              memwb_en;
  logic              memwb_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        fwd_id_a;
  logic [1:0]        fwd_id_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= RUN;
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    freeze = 1'b0;
    unique case (st_q)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          st_d   = DWAIT;
          wcnt_d = WW'(1);
          freeze = 1'b1;
        end
      end
      DWAIT: begin
        if (hz.dmem_ready) begin
          st_d   = RUN;
          wcnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wcnt_q == TMO) begin
            st_d   = ABORT;
            wcnt_d = '0;
            err_d  = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      ABORT: begin
        st_d   = RUN;
        wcnt_d = '0;
      end
      default: begin
        st_d   = RUN;
        wcnt_d = '0;
      end
    endcase
    // Held in reset the FSM cannot freeze the pipe.
    if (!reset)
      freeze = 1'b0;
  end

  assign abort_c = (st_q == ABORT);

  always_comb begin
    ex_ld  = src_hit(hz.ex_memread, hz.ex_rd,
                     hz.id_use_rs1, hz.id_rs1,
                     hz.id_use_rs2, hz.id_rs2);
    ex_wr  = src_hit(hz.ex_regwrite, hz.ex_rd,
                     hz.id_use_rs1, hz.id_rs1,
                     hz.id_use_rs2, hz.id_rs2);
    mem_ld = src_hit(hz.mem_memread, hz.mem_rd,
                     hz.id_use_rs1, hz.id_rs1,
                     hz.id_use_rs2, hz.id_rs2);
    mem_wr = src_hit(hz.mem_regwrite, hz.mem_rd,
                     hz.id_use_rs1, hz.id_rs1,
                     hz.id_use_rs2, hz.id_rs2);
    wb_wr  = src_hit(hz.wb_regwrite, hz.wb_rd,
                     hz.id_use_rs1, hz.id_rs1,
                     hz.id_use_rs2, hz.id_rs2);
    if (FWD_EN != 0)
      stall_raw = ex_ld ||
        (hz.id_branch && (ex_wr || mem_ld));
    else
      stall_raw = ex_ld || ex_wr || mem_ld ||
        mem_wr || wb_wr;
  end

  assign stall_e = stall_raw && !freeze && !abort_c;
  assign redir_e = hz.redirect && !stall_raw &&
                   !freeze && !abort_c;
  assign iwait_e = !hz.imem_ready && !hz.redirect &&
                   !stall_raw && !freeze && !abort_c;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        memwb_bubble = 1'b1;
      end
      abort_c: begin
        memwb_bubble = 1'b1;
      end
      stall_e: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      redir_e: begin
        ifid_flush = 1'b1;
      end
      iwait_e: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    fwd_id_a = 2'b00;
    fwd_id_b = 2'b00;
    if (FWD_EN != 0) begin
      fwd_a = fwd_sel(hz.mem_regwrite, hz.mem_rd,
                      hz.wb_regwrite, hz.wb_rd, hz.ex_rs1);
      if (!hz.ex_alusrc)
        fwd_b = fwd_sel(hz.mem_regwrite, hz.mem_rd,
                        hz.wb_regwrite, hz.wb_rd, hz.ex_rs2);
      // A MEM-stage load has no data yet; the branch stall covers it.
      fwd_id_a = fwd_sel(hz.mem_regwrite && !hz.mem_memread,
                         hz.mem_rd, hz.wb_regwrite, hz.wb_rd,
                         hz.id_rs1);
      fwd_id_b = fwd_sel(hz.mem_regwrite && !hz.mem_memread,
                         hz.mem_rd, hz.wb_regwrite, hz.wb_rd,
                         hz.id_rs2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_q <= '0;
      fcnt_q <= '0;
    end else if (hz.cnt_clr) begin
      scnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      if ((stall_e || freeze) && (scnt_q != CMAX))
        scnt_q <= scnt_q + CNT_W'(1);
      if (ifid_flush && (fcnt_q != CMAX))
        fcnt_q <= fcnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.fwd_id_a     = fwd_id_a;
  assign hz.fwd_id_b     = fwd_id_b;
  assign hz.dmem_err     = err_q;
  assign hz.stall_cnt    = scnt_q;
  assign hz.flush_cnt    = fcnt_q;
  assign hz.state        = st_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding build and a
// stall-only build with narrow counters share clock and reset.
module tb_hazard_ctrl_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   e_stall;
  int   e_flush;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) hzi ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  hzn ();

  hazard_ctrl_unit #(
    .REG_AW(5), .FWD_EN(1), .CNT_W(16), .DMEM_TMO(15)
  ) u_fwd (
    .clk  (clk),
    .reset(reset),
    .hz   (hzi)
  );

  hazard_ctrl_unit #(
    .REG_AW(5), .FWD_EN(0), .CNT_W(4), .DMEM_TMO(15)
  ) u_nf (
    .clk  (clk),
    .reset(reset),
    .hz   (hzn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int s, input int f);
    @(posedge clk);
    #1;
    e_stall += s;
    e_flush += f;
  endtask

  task automatic idle_i();
    hzi.id_rs1 = '0; hzi.id_rs2 = '0;
    hzi.id_use_rs1 = 0; hzi.id_use_rs2 = 0;
    hzi.id_branch = 0; hzi.redirect = 0;
    hzi.ex_rd = '0; hzi.ex_rs1 = '0; hzi.ex_rs2 = '0;
    hzi.ex_regwrite = 0; hzi.ex_memread = 0;
    hzi.ex_alusrc = 0;
    hzi.mem_rd = '0; hzi.mem_regwrite = 0;
    hzi.mem_memread = 0; hzi.dmem_req = 0;
    hzi.wb_rd = '0; hzi.wb_regwrite = 0;
    hzi.imem_ready = 1; hzi.dmem_ready = 1;
    hzi.cnt_clr = 0;
  endtask

  task automatic idle_n();
    hzn.id_rs1 = '0; hzn.id_rs2 = '0;
    hzn.id_use_rs1 = 0; hzn.id_use_rs2 = 0;
    hzn.id_branch = 0; hzn.redirect = 0;
    hzn.ex_rd = '0; hzn.ex_rs1 = '0; hzn.ex_rs2 = '0;
    hzn.ex_regwrite = 0; hzn.ex_memread = 0;
    hzn.ex_alusrc = 0;
    hzn.mem_rd = '0; hzn.mem_regwrite = 0;
    hzn.mem_memread = 0; hzn.dmem_req = 0;
    hzn.wb_rd = '0; hzn.wb_regwrite = 0;
    hzn.imem_ready = 1; hzn.dmem_ready = 1;
    hzn.cnt_clr = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e_stall = 0;
    e_flush = 0;
    reset = 1'b0;
    idle_i();
    idle_n();

    // in reset: outputs follow inputs, no freeze
    #2;
    hzi.dmem_req = 1; hzi.dmem_ready = 0;
    hzi.mem_regwrite = 1; hzi.mem_rd = 5'd3;
    hzi.ex_rs1 = 5'd3;
    #1;
    chk("rst_state", hzi.state, 2'b00);
    chk("rst_pc_en", hzi.pc_en, 1'b1);
    chk("rst_mwbub", hzi.memwb_bubble, 1'b0);
    chk("rst_err", hzi.dmem_err, 1'b0);
    chk("rst_scnt", hzi.stall_cnt, 16'd0);
    chk("rst_fcnt", hzi.flush_cnt, 16'd0);
    chk("rst_fwd_a", hzi.fwd_a, 2'b10);
    idle_i();
    #9 reset = 1'b1;
    tick(0, 0);

    // forwarding
    hzi.mem_rd = 5'd3; hzi.wb_rd = 5'd3;
    hzi.mem_regwrite = 1; hzi.wb_regwrite = 1;
    hzi.ex_rs1 = 5'd3; hzi.id_rs1 = 5'd3;
    #1;
    chk("fwd_a_mem", hzi.fwd_a, 2'b10);
    chk("fwd_id_a_mem", hzi.fwd_id_a, 2'b10);
    hzi.mem_memread = 1;
    #1;
    chk("fwd_id_a_ld", hzi.fwd_id_a, 2'b01);
    hzi.mem_memread = 0;
    hzi.mem_regwrite = 0;
    #1;
    chk("fwd_a_wb", hzi.fwd_a, 2'b01);
    hzi.ex_rs2 = 5'd3; hzi.ex_alusrc = 1;
    #1;
    chk("fwd_b_imm", hzi.fwd_b, 2'b00);
    hzi.ex_alusrc = 0;
    #1;
    chk("fwd_b_wb", hzi.fwd_b, 2'b01);
    hzi.ex_rs1 = '0;
    #1;
    chk("fwd_a_x0", hzi.fwd_a, 2'b00);
    idle_i();
    tick(0, 0);
    chk("idle_scnt", hzi.stall_cnt, 16'(e_stall));

    // load-use
    hzi.ex_memread = 1; hzi.ex_rd = 5'd5;
    hzi.id_rs1 = 5'd5; hzi.id_use_rs1 = 1;
    #1;
    chk("lu_pc_en", hzi.pc_en, 1'b0);
    chk("lu_ifid_en", hzi.ifid_en, 1'b0);
    chk("lu_idex_bub", hzi.idex_bubble, 1'b1);
    chk("lu_exmem_en", hzi.exmem_en, 1'b1);
    chk("lu_memwb_en", hzi.memwb_en, 1'b1);
    tick(1, 0);
    chk("lu_scnt", hzi.stall_cnt, 16'(e_stall));
    idle_i();

    // branch-operand stall beats redirect
    hzi.id_branch = 1; hzi.ex_regwrite = 1;
    hzi.ex_rd = 5'd4; hzi.id_rs1 = 5'd4;
    hzi.id_use_rs1 = 1; hzi.redirect = 1;
    #1;
    chk("br_flush", hzi.ifid_flush, 1'b0);
    chk("br_pc_en", hzi.pc_en, 1'b0);
    chk("br_bub", hzi.idex_bubble, 1'b1);
    tick(1, 0);
    hzi.id_branch = 0; hzi.ex_regwrite = 0;
    #1;
    chk("rd_flush", hzi.ifid_flush, 1'b1);
    chk("rd_pc_en", hzi.pc_en, 1'b1);
    chk("rd_bub", hzi.idex_bubble, 1'b0);
    tick(0, 1);
    chk("rd_fcnt", hzi.flush_cnt, 16'(e_flush));
    chk("rd_scnt", hzi.stall_cnt, 16'(e_stall));
    idle_i();

    // imem wait, then redirect while imem waits
    hzi.imem_ready = 0;
    #1;
    chk("iw_pc_en", hzi.pc_en, 1'b0);
    chk("iw_flush", hzi.ifid_flush, 1'b1);
    hzi.redirect = 1;
    #1;
    chk("iwr_pc_en", hzi.pc_en, 1'b1);
    tick(0, 1);
    chk("iw_fcnt", hzi.flush_cnt, 16'(e_flush));
    idle_i();

    // data wait: 3 frozen cycles then ready
    hzi.dmem_req = 1; hzi.dmem_ready = 0;
    #1;
    chk("dw_state0", hzi.state, 2'b00);
    chk("dw_pc_en", hzi.pc_en, 1'b0);
    chk("dw_ifid_en", hzi.ifid_en, 1'b0);
    chk("dw_idex_en", hzi.idex_en, 1'b0);
    chk("dw_exmem_en", hzi.exmem_en, 1'b0);
    chk("dw_memwb_en", hzi.memwb_en, 1'b0);
    chk("dw_mwbub", hzi.memwb_bubble, 1'b1);
    chk("dw_idbub", hzi.idex_bubble, 1'b0);
    tick(1, 0);
    chk("dw_state1", hzi.state, 2'b01);
    chk("dw_pc_en1", hzi.pc_en, 1'b0);
    tick(1, 0);
    chk("dw_state2", hzi.state, 2'b01);
    tick(1, 0);
    hzi.dmem_ready = 1;
    #1;
    chk("dw_rel_st", hzi.state, 2'b01);
    chk("dw_rel_pc", hzi.pc_en, 1'b1);
    chk("dw_rel_mb", hzi.memwb_bubble, 1'b0);
    tick(0, 0);
    hzi.dmem_req = 0;
    chk("dw_run", hzi.state, 2'b00);
    chk("dw_err", hzi.dmem_err, 1'b0);
    chk("dw_scnt", hzi.stall_cnt, 16'(e_stall));

    // clear wins over a stall increment
    hzi.cnt_clr = 1;
    hzi.ex_memread = 1; hzi.ex_rd = 5'd5;
    hzi.id_rs1 = 5'd5; hzi.id_use_rs1 = 1;
    tick(0, 0);
    e_stall = 0;
    e_flush = 0;
    chk("clr_scnt", hzi.stall_cnt, 16'd0);
    chk("clr_fcnt", hzi.flush_cnt, 16'd0);
    idle_i();

    // timeout into ABORT
    hzi.dmem_req = 1; hzi.dmem_ready = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(1, 0);
      if (hzi.state !== 2'b01 || i == 15)
        chk($sformatf("to_wait%0d", i), hzi.state, 2'b01);
    end
    chk("to_err0", hzi.dmem_err, 1'b0);
    tick(1, 0);
    hzi.dmem_req = 0;
    #1;
    chk("to_abort", hzi.state, 2'b10);
    chk("to_err1", hzi.dmem_err, 1'b1);
    chk("ab_pc_en", hzi.pc_en, 1'b1);
    chk("ab_memwb_en", hzi.memwb_en, 1'b1);
    chk("ab_mwbub", hzi.memwb_bubble, 1'b1);
    tick(0, 0);
    chk("ab_run", hzi.state, 2'b00);
    chk("ab_sticky", hzi.dmem_err, 1'b1);
    chk("to_scnt", hzi.stall_cnt, 16'(e_stall));

    // reset in the middle of a wait
    hzi.dmem_req = 1; hzi.dmem_ready = 0;
    tick(1, 0);
    chk("rw_state", hzi.state, 2'b01);
    #2 reset = 1'b0;
    #1;
    chk("rw_rst_st", hzi.state, 2'b00);
    chk("rw_rst_err", hzi.dmem_err, 1'b0);
    chk("rw_rst_sc", hzi.stall_cnt, 16'd0);
    chk("rw_rst_pc", hzi.pc_en, 1'b1);
    idle_i();
    idle_n();
    #2 reset = 1'b1;
    e_stall = 0;
    e_flush = 0;
    tick(0, 0);
    chk("rw_run", hzi.state, 2'b00);
    chk("rw_err", hzi.dmem_err, 1'b0);

    // stall-only build
    hzn.wb_regwrite = 1; hzn.wb_rd = 5'd7;
    hzn.id_rs2 = 5'd7; hzn.id_use_rs2 = 1;
    hzn.ex_rs1 = 5'd7; hzn.ex_rs2 = 5'd7;
    hzn.id_rs1 = 5'd7;
    #1;
    chk("nf_pc_en", hzn.pc_en, 1'b0);
    chk("nf_bub", hzn.idex_bubble, 1'b1);
    chk("nf_fwd_a", hzn.fwd_a, 2'b00);
    chk("nf_fwd_b", hzn.fwd_b, 2'b00);
    chk("nf_fwd_ida", hzn.fwd_id_a, 2'b00);
    chk("nf_fwd_idb", hzn.fwd_id_b, 2'b00);
    hzn.cnt_clr = 1;
    tick(0, 0);
    hzn.cnt_clr = 0;
    chk("nf_clr", hzn.stall_cnt, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0);
      if (i == 14)
        chk("nf_cnt14", hzn.stall_cnt, 4'd14);
      if (i == 15)
        chk("nf_cnt15", hzn.stall_cnt, 4'd15);
    end
    chk("nf_sat", hzn.stall_cnt, 4'd15);
    idle_n();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
